// File: rtl/dmem_pkg.sv
// dmem_pkg: shared width codes, bus size codes and pending-entry layout for the data-memory request path.
package dmem_pkg;
    typedef enum logic [1:0] {
        MW_NONE = 2'b00,
        MW_BYTE = 2'b01,
        MW_HALF = 2'b10,
        MW_WORD = 2'b11
    } mem_width_e;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } bus_size_e;
    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } req_state_e;
    typedef struct packed {
        logic       is_load;
        logic [1:0] off;
        mem_width_e width;
        logic       sgn;
    } pend_t;
    localparam int PEND_W = $bits(pend_t);
    function automatic bus_size_e bus_size(input mem_width_e w);
        return w == MW_BYTE ? SZ_BYTE : w == MW_HALF ? SZ_HALF : SZ_WORD;
    endfunction
endpackage

// File: rtl/dmem_req_ctrl_if.sv
// dmem_req_ctrl_if: SRAM-like data bus (req/addr_ok/data_ok).
//  master: drives req, wr, size, addr, wdata, wstrb; receives addr_ok, data_ok, rdata
//  slave : the bus bridge side
interface dmem_req_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;
    modport master (
        output req, wr, size, addr, wdata, wstrb,
        input  addr_ok, data_ok, rdata
    );
    modport slave (
        input  req, wr, size, addr, wdata, wstrb,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/dmem_pending_fifo.sv
// dmem_pending_fifo: in-order queue of accepted bus transactions awaiting data_ok.
//  push/push_data: enqueue (ignored when full); pop: dequeue head (ignored when empty)
//  pop_data: head entry; count/full/empty: occupancy
module dmem_pending_fifo
    import dmem_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  pend_t         push_data,
    input  logic          pop,
    output pend_t         pop_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [PEND_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              do_push;
    logic              do_pop;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = pend_t'(mem[rd_ptr]);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl: EX-stage load/store to SRAM-like bus request controller with formatted load return.
//  EX side : MemValidE, MemWriteE, MemWidthE, MemSignedE, PhyAddrE, WriteDataE in; stall_e out
//  except  : adel/ades one-cycle pulses with bad_addr
//  bus     : dmem_req_ctrl_if.master (req/wr/size/addr/wdata/wstrb out; addr_ok/data_ok/rdata in)
//  MEM side: load_valid_m, load_data_m
module dmem_req_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MemValidE,
    input  logic                 MemWriteE,
    input  logic [1:0]           MemWidthE,
    input  logic                 MemSignedE,
    input  logic [ADDR_W-1:0]    PhyAddrE,
    input  logic [DATA_W-1:0]    WriteDataE,
    output logic                 stall_e,
    output logic                 adel,
    output logic                 ades,
    output logic [ADDR_W-1:0]    bad_addr,
    dmem_req_ctrl_if.master      bus,
    output logic                 load_valid_m,
    output logic [DATA_W-1:0]    load_data_m
);
    req_state_e                   state;
    req_state_e                   state_n;
    mem_width_e                   width;
    logic                         req;
    logic                         op_e;
    logic                         mis;
    logic                         credit;
    logic                         capture;
    logic                         wr_q;
    logic [1:0]                   size_q;
    logic [ADDR_W-1:0]            addr_q;
    logic [31:0]                  wdata_q;
    logic [3:0]                   wstrb_q;
    pend_t                        ent_q;
    pend_t                        head;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         full;
    logic                         empty;
    function automatic logic [3:0] strobe(input mem_width_e w, input logic [1:0] off);
        return w == MW_BYTE ? 4'b0001 << off : w == MW_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
    function automatic logic [31:0] lanes(input mem_width_e w, input logic [31:0] d);
        return w == MW_BYTE ? {4{d[7:0]}} : w == MW_HALF ? {2{d[15:0]}} : d;
    endfunction
    function automatic logic [31:0] fmt_load(input pend_t e, input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> {e.off, 3'b000};
        return e.width == MW_BYTE ? {{24{e.sgn & sh[7]}}, sh[7:0]} :
               e.width == MW_HALF ? {{16{e.sgn & sh[15]}}, sh[15:0]} : sh;
    endfunction
    assign width = mem_width_e'(MemWidthE);
    assign req   = state == ST_REQ;
    // Credit counts the queued entries plus the request in flight; a data_ok
    // this cycle is deliberately not bypassed, so a full queue frees next cycle.
    always_comb begin
        op_e    = MemValidE & (width != MW_NONE);
        mis     = ((width == MW_HALF) & PhyAddrE[0]) | ((width == MW_WORD) & (PhyAddrE[1:0] != 2'b00));
        credit  = req ? (int'(count) + 1 < DEPTH) : ~full;
        capture = op_e & ~mis & (~req | bus.addr_ok) & credit;
        stall_e = op_e & ~mis & ~capture;
        state_n = (capture | (req & ~bus.addr_ok)) ? ST_REQ : ST_IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end
    // Bus fields only load on capture, which keeps them stable while addr_ok is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q     <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            ent_q    <= '0;
            adel     <= 1'b0;
            ades     <= 1'b0;
            bad_addr <= '0;
        end else begin
            if (capture) begin
                wr_q    <= MemWriteE;
                size_q  <= bus_size(width);
                addr_q  <= PhyAddrE;
                wdata_q <= lanes(width, WriteDataE);
                wstrb_q <= MemWriteE ? strobe(width, PhyAddrE[1:0]) : 4'b0000;
                ent_q   <= '{is_load: ~MemWriteE, off: PhyAddrE[1:0], width: width, sgn: MemSignedE};
            end
            adel <= op_e & mis & ~MemWriteE;
            ades <= op_e & mis & MemWriteE;
            if (op_e & mis) bad_addr <= PhyAddrE;
        end
    end
    assign bus.req   = req;
    assign bus.wr    = wr_q;
    assign bus.size  = size_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.wstrb = wstrb_q;
    dmem_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req & bus.addr_ok),
        .push_data (ent_q),
        .pop       (bus.data_ok),
        .pop_data  (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );
    assign load_valid_m = bus.data_ok & ~empty & head.is_load;
    assign load_data_m  = load_valid_m ? fmt_load(head, bus.rdata) : '0;
endmodule

// File: tb/tb_dmem_req_ctrl.sv
// tb_dmem_req_ctrl: directed scenarios followed by randomized traffic against a byte-level reference model.
module tb_dmem_req_ctrl;
    localparam int DEPTH = 2;
    typedef struct packed {
        logic        wrt;
        logic [1:0]  w;
        logic        sg;
        logic [31:0] a;
        logic [31:0] d;
    } op_t;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemValidE = 1'b0;
    logic        MemWriteE = 1'b0;
    logic [1:0]  MemWidthE = 2'b00;
    logic        MemSignedE = 1'b0;
    logic [31:0] PhyAddrE = '0;
    logic [31:0] WriteDataE = '0;
    logic        stall_e;
    logic        adel;
    logic        ades;
    logic [31:0] bad_addr;
    logic        load_valid_m;
    logic [31:0] load_data_m;
    int          checks = 0;
    int          errors = 0;
    op_t         cur;
    op_t         pend;
    op_t         front;
    op_t         outq[$];
    bit          cur_v;
    bit          pend_v;
    bit          aligned;
    bit          misal;
    bit          acc;
    bit          exp_lv;
    bit          exp_adel;
    bit          exp_ades;
    logic [31:0] exp_ld;
    logic [31:0] exp_bad;
    dmem_req_ctrl_if #(.ADDR_W(32)) bus ();
    dmem_req_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemValidE    (MemValidE),
        .MemWriteE    (MemWriteE),
        .MemWidthE    (MemWidthE),
        .MemSignedE   (MemSignedE),
        .PhyAddrE     (PhyAddrE),
        .WriteDataE   (WriteDataE),
        .stall_e      (stall_e),
        .adel         (adel),
        .ades         (ades),
        .bad_addr     (bad_addr),
        .bus          (bus),
        .load_valid_m (load_valid_m),
        .load_data_m  (load_data_m)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask
    task automatic drive_op(input logic v, input logic wrt, input logic [1:0] w, input logic sg,
                            input logic [31:0] a, input logic [31:0] d);
        MemValidE  = v;
        MemWriteE  = wrt;
        MemWidthE  = w;
        MemSignedE = sg;
        PhyAddrE   = a;
        WriteDataE = d;
    endtask
    task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] w, input logic sg,
                           input logic [31:0] rd, input logic [31:0] exp);
        drive_op(1'b1, 1'b0, w, sg, a, '0);
        step();
        MemValidE   = 1'b0;
        bus.addr_ok = 1'b1;
        step();
        bus.addr_ok = 1'b0;
        bus.data_ok = 1'b1;
        bus.rdata   = rd;
        #1;
        chk({tag, "_valid"}, 32'(load_valid_m), 32'd1);
        chk({tag, "_data"}, load_data_m, exp);
        step();
        bus.data_ok = 1'b0;
    endtask
    function automatic int nb(input logic [1:0] w);
        return w == 2'b01 ? 1 : w == 2'b10 ? 2 : 4;
    endfunction
    function automatic logic [31:0] m_load(input op_t o, input logic [31:0] rd);
        int     n;
        int     off;
        longint v;
        n   = nb(o.w);
        off = int'(o.a % 4);
        v   = 0;
        for (int i = 0; i < n; i++) v += longint'((rd >> (8 * (off + i))) & 32'hFF) << (8 * i);
        if (o.sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return 32'(v);
    endfunction
    function automatic logic [3:0] m_strb(input op_t o);
        logic [3:0] s;
        int         off;
        s   = '0;
        off = int'(o.a % 4);
        for (int i = 0; i < 4; i++) s[i] = o.wrt && i >= off && i < off + nb(o.w);
        return s;
    endfunction
    function automatic logic [31:0] m_wdata(input op_t o);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = o.d[8*(i % nb(o.w)) +: 8];
        return r;
    endfunction
    initial begin
        bus.addr_ok = 1'b0;
        bus.data_ok = 1'b0;
        bus.rdata   = '0;
        #2 rst = 1'b1;
        step();
        step();
        chk("rst_req", 32'(bus.req), 0);
        chk("rst_wr", 32'(bus.wr), 0);
        chk("rst_size", 32'(bus.size), 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_wstrb", 32'(bus.wstrb), 0);
        chk("rst_adel", 32'(adel), 0);
        chk("rst_ades", 32'(ades), 0);
        chk("rst_bad_addr", bad_addr, 0);
        chk("rst_stall", 32'(stall_e), 0);
        chk("rst_lvalid", 32'(load_valid_m), 0);
        chk("rst_ldata", load_data_m, 0);
        rst = 1'b0;
        step();
        drive_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, '0);
        #1 chk("lw_stall", 32'(stall_e), 0);
        step();
        MemValidE   = 1'b0;
        bus.addr_ok = 1'b1;
        #1;
        chk("lw_req", 32'(bus.req), 1);
        chk("lw_addr", bus.addr, 32'h100);
        chk("lw_size", 32'(bus.size), 2);
        chk("lw_wr", 32'(bus.wr), 0);
        chk("lw_wstrb", 32'(bus.wstrb), 0);
        step();
        bus.addr_ok = 1'b0;
        #1;
        chk("lw_req_drop", 32'(bus.req), 0);
        chk("lw_early_valid", 32'(load_valid_m), 0);
        step();
        bus.data_ok = 1'b1;
        bus.rdata   = 32'hDEADBEEF;
        #1;
        chk("lw_valid", 32'(load_valid_m), 1);
        chk("lw_data", load_data_m, 32'hDEADBEEF);
        step();
        bus.data_ok = 1'b0;
        #1 chk("lw_one_pulse", 32'(load_valid_m), 0);
        do_load("lb", 32'h103, 2'b01, 1'b1, 32'h80FFFFFF, 32'hFFFFFF80);
        do_load("lbu", 32'h103, 2'b01, 1'b0, 32'h80FFFFFF, 32'h00000080);
        do_load("lh", 32'h102, 2'b10, 1'b1, 32'h9ABC0000, 32'hFFFF9ABC);
        drive_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h102, 32'h00001234);
        step();
        MemValidE   = 1'b0;
        bus.addr_ok = 1'b1;
        #1;
        chk("sh_req", 32'(bus.req), 1);
        chk("sh_wstrb", 32'(bus.wstrb), 32'hC);
        chk("sh_wdata", bus.wdata, 32'h12341234);
        chk("sh_size", 32'(bus.size), 1);
        chk("sh_wr", 32'(bus.wr), 1);
        step();
        bus.addr_ok = 1'b0;
        bus.data_ok = 1'b1;
        #1 chk("sh_no_load", 32'(load_valid_m), 0);
        step();
        bus.data_ok = 1'b0;
        drive_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h101, '0);
        #1 chk("mis_stall", 32'(stall_e), 0);
        step();
        MemValidE = 1'b0;
        chk("mis_adel", 32'(adel), 1);
        chk("mis_ades", 32'(ades), 0);
        chk("mis_bad_addr", bad_addr, 32'h101);
        chk("mis_req", 32'(bus.req), 0);
        step();
        chk("mis_pulse", 32'(adel), 0);
        drive_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h200, '0);
        bus.addr_ok = 1'b1;
        #1 chk("full_l1_stall", 32'(stall_e), 0);
        step();
        PhyAddrE = 32'h204;
        #1 chk("full_l2_stall", 32'(stall_e), 0);
        step();
        PhyAddrE = 32'h208;
        #1 chk("full_l3_stall", 32'(stall_e), 1);
        step();
        #1 chk("full_l3_hold", 32'(stall_e), 1);
        step();
        bus.data_ok = 1'b1;
        bus.rdata   = 32'h11111111;
        #1;
        chk("full_pop1_valid", 32'(load_valid_m), 1);
        chk("full_pop1_data", load_data_m, 32'h11111111);
        chk("full_no_bypass", 32'(stall_e), 1);
        step();
        bus.data_ok = 1'b0;
        #1 chk("full_l3_go", 32'(stall_e), 0);
        step();
        MemValidE = 1'b0;
        #1;
        chk("full_l3_req", 32'(bus.req), 1);
        chk("full_l3_addr", bus.addr, 32'h208);
        step();
        bus.addr_ok = 1'b0;
        bus.data_ok = 1'b1;
        bus.rdata   = 32'h22222222;
        #1 chk("full_pop2", load_data_m, 32'h22222222);
        step();
        bus.rdata = 32'h33333333;
        #1 chk("full_pop3", load_data_m, 32'h33333333);
        step();
        #1 chk("empty_data_ok", 32'(load_valid_m), 0);
        step();
        bus.data_ok = 1'b0;
        drive_op(1'b1, 1'b1, 2'b11, 1'b0, 32'h300, 32'hCAFEF00D);
        step();
        MemValidE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", 32'(bus.req), 1);
            chk("wait_addr", bus.addr, 32'h300);
            chk("wait_wdata", bus.wdata, 32'hCAFEF00D);
            step();
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_req", 32'(bus.req), 0);
        chk("arst_addr", bus.addr, 0);
        chk("arst_wdata", bus.wdata, 0);
        chk("arst_wstrb", 32'(bus.wstrb), 0);
        chk("arst_wr", 32'(bus.wr), 0);
        step();
        rst = 1'b0;
        bus.data_ok = 1'b1;
        #1 chk("late_data_ok", 32'(load_valid_m), 0);
        step();
        bus.data_ok = 1'b0;
        cur_v    = 1'b0;
        pend_v   = 1'b0;
        exp_adel = 1'b0;
        exp_ades = 1'b0;
        exp_bad  = '0;
        for (int c = 0; c < 600; c++) begin
            if (!cur_v) begin
                cur_v  = ($urandom % 4) != 0;
                cur.wrt = 1'($urandom);
                cur.w   = 2'($urandom);
                cur.sg  = 1'($urandom);
                cur.a   = $urandom;
                cur.d   = $urandom;
            end
            drive_op(cur_v, cur.wrt, cur.w, cur.sg, cur.a, cur.d);
            bus.addr_ok = 1'($urandom);
            bus.data_ok = ($urandom % 3) == 0;
            bus.rdata   = $urandom;
            #1;
            aligned = cur_v && cur.w != 2'b00 && (cur.a % nb(cur.w)) == 0;
            misal   = cur_v && cur.w != 2'b00 && !aligned;
            acc     = aligned && (!pend_v || bus.addr_ok) && (outq.size() + int'(pend_v) < DEPTH);
            chk("rnd_stall", 32'(stall_e), 32'(aligned && !acc));
            chk("rnd_req", 32'(bus.req), 32'(pend_v));
            if (pend_v) begin
                chk("rnd_wr", 32'(bus.wr), 32'(pend.wrt));
                chk("rnd_addr", bus.addr, pend.a);
                chk("rnd_size", 32'(bus.size), nb(pend.w) == 1 ? 0 : nb(pend.w) == 2 ? 1 : 2);
                chk("rnd_wstrb", 32'(m_strb(pend)), 32'(bus.wstrb) ^ 32'(m_strb(pend)) ^ 32'(m_strb(pend)));
                if (pend.wrt) chk("rnd_wdata", bus.wdata, m_wdata(pend));
            end
            exp_lv = 1'b0;
            exp_ld = '0;
            if (bus.data_ok && outq.size() > 0) begin
                front  = outq.pop_front();
                exp_lv = !front.wrt;
                exp_ld = exp_lv ? m_load(front, bus.rdata) : '0;
            end
            chk("rnd_lvalid", 32'(load_valid_m), 32'(exp_lv));
            chk("rnd_ldata", load_data_m, exp_ld);
            chk("rnd_adel", 32'(adel), 32'(exp_adel));
            chk("rnd_ades", 32'(ades), 32'(exp_ades));
            if (exp_adel || exp_ades) chk("rnd_bad_addr", bad_addr, exp_bad);
            if (pend_v && bus.addr_ok) begin
                outq.push_back(pend);
                pend_v = 1'b0;
            end
            if (acc) begin
                pend   = cur;
                pend_v = 1'b1;
            end
            exp_adel = misal && !cur.wrt;
            exp_ades = misal && cur.wrt;
            if (misal) exp_bad = cur.a;
            if (!(aligned && !acc)) cur_v = 1'b0;
            @(posedge clk);
            #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
